ofdm_adc_capture: RTL and testbench



---
 rtl/ofdm_adc_capture_if.sv | 12 +
 rtl/ofdm_adc_capture.sv | 160 ++++++++++++++++
 tb/tb_ofdm_adc_capture.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_adc_capture_if.sv
// Avalon-ST source bundle carrying captured I/Q words {real16, imag16, exp6}
// together with their packet-boundary flags.
interface ofdm_adc_capture_if;
    logic [37:0] data;
    logic        valid;
    logic        ready;
    logic        startofpacket;
    logic        endofpacket;

    modport master (output data, output valid, output startofpacket, output endofpacket, input ready);
    modport slave  (input data, input valid, input startofpacket, input endofpacket, output ready);
endinterface

// File: rtl/ofdm_adc_capture.sv
// Dual-channel ADC capture: offset-binary to I/Q conversion, frame admission into a show-ahead FIFO.
// Define OFDM_ADC_CAPTURE_TESTPAT_EN to replace ADC data with a ramp / inverted-ramp test pattern.
module ofdm_adc_capture #(
    parameter int FRAME_LEN  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                      sample_clock_adc,
    input  logic                      reset_reset_n,
    input  logic [13:0]               ADC_Capture_ChA_Data,
    input  logic [13:0]               ADC_Capture_ChB_Data,
    input  logic                      capture_enable,
    ofdm_adc_capture_if.master        aso_out0,
    output logic                      capture_busy,
    output logic [15:0]               drop_count
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, SKIP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [13:0]       s_a_q, s_b_q;
    logic [15:0]       drop_q;
    logic              busy_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       fifo_cnt_q;
    logic [39:0]       mem_q [FIFO_DEPTH];
    logic [39:0]       head;
    logic [15:0]       re_w, im_w;
    logic              wr_en, wr_sop, wr_eop, drop_inc;
    logic              fits, last, pop, valid;

    assign last  = (cnt_q == CNT_W'(FRAME_LEN - 1));
    // Free space is judged on occupancy before this edge; a same-edge pop is not credited.
    assign fits  = (fifo_cnt_q <= (AW+1)'(FIFO_DEPTH - FRAME_LEN));
    assign valid = (fifo_cnt_q != '0);
    assign pop   = valid & aso_out0.ready;

    always_ff @(posedge sample_clock_adc or negedge reset_reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_reset_n) begin
            s_a_q <= '0;
            s_b_q <= '0;
        end else begin
            s_a_q <= ADC_Capture_ChA_Data;
            s_b_q <= ADC_Capture_ChB_Data;
        end
    end

`ifdef OFDM_ADC_CAPTURE_TESTPAT_EN
    logic [15:0] ramp_q;
    logic        unused_pins;

    always_ff @(posedge sample_clock_adc or negedge reset_reset_n) begin
        if (!reset_reset_n)  ramp_q <= '0;
        else if (wr_en)      ramp_q <= ramp_q + 16'd1;
    end

    assign re_w        = ramp_q;
    assign im_w        = ~ramp_q;
    assign unused_pins = ^{s_a_q, s_b_q};
`else
    logic unused_lsbs;

    // Flip the offset-binary MSB to get a signed 12-bit value, then sign-extend.
    assign re_w        = {{5{~s_a_q[13]}}, s_a_q[12:2]};
    assign im_w        = {{5{~s_b_q[13]}}, s_b_q[12:2]};
    assign unused_lsbs = ^{s_a_q[1:0], s_b_q[1:0]};
`endif

    always_ff @(posedge sample_clock_adc or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (capture_enable) begin
                    state_d = fits ? WRITE : SKIP;
                    cnt_d   = CNT_W'(1);
                end
            end
            WRITE, SKIP: begin
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_sop   = 1'b0;
        wr_eop   = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_en    = capture_enable & fits;
                wr_sop   = capture_enable & fits;
                drop_inc = capture_enable & ~fits;
            end
            WRITE: begin
                wr_en  = 1'b1;
                wr_eop = last;
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; validity is tracked solely by the pointers and count.
    always_ff @(posedge sample_clock_adc) begin
        if (wr_en) mem_q[wr_ptr_q] <= {wr_sop, wr_eop, re_w, im_w, 6'd0};
    end

    always_ff @(posedge sample_clock_adc or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Gate the head with valid so an empty FIFO never exposes stale or uninitialised storage.
    assign head                   = mem_q[rd_ptr_q];
    assign aso_out0.valid         = valid;
    assign aso_out0.data          = valid ? head[37:0] : '0;
    assign aso_out0.startofpacket = valid & head[39];
    assign aso_out0.endofpacket   = valid & head[38];
    assign capture_busy           = busy_q;
    assign drop_count             = drop_q;
endmodule

// File: tb/tb_ofdm_adc_capture.sv
// Randomised bench for ofdm_adc_capture against a frame-level queue model of the
// capture path; honours OFDM_ADC_CAPTURE_TESTPAT_EN when defined.
module tb_ofdm_adc_capture;
    localparam int FL = 64;
    localparam int FD = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] cha = '0, chb = '0;
    logic        en = 1'b0;
    logic        busy;
    logic [15:0] drops;

    ofdm_adc_capture_if bus ();

    ofdm_adc_capture #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .sample_clock_adc     (clk),
        .reset_reset_n        (rst_n),
        .ADC_Capture_ChA_Data (cha),
        .ADC_Capture_ChB_Data (chb),
        .capture_enable       (en),
        .aso_out0             (bus.master),
        .capture_busy         (busy),
        .drop_count           (drops)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] re;
        logic [15:0] im;
    } word_t;

    word_t       q[$];
    logic [13:0] m_a = '0, m_b = '0;
    logic [15:0] m_ramp = '0;
    int          left = 0;
    bit          keep = 1'b0;
    int          m_drops = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_count = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dut.wr_en && dut.fifo_cnt_q == FD))
                else $error("FAIL fifo_write_while_full");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    // Offset binary to signed: drop two LSBs, remove the mid-scale offset.
    function automatic logic [15:0] conv(input logic [13:0] p);
        int v;
        v = int'(p) / 4 - 2048;
        return 16'(v);
    endfunction

    function automatic word_t make_word(input bit sop, input bit eop);
        word_t w;
        w.sop = sop;
        w.eop = eop;
`ifdef OFDM_ADC_CAPTURE_TESTPAT_EN
        w.re  = m_ramp;
        w.im  = ~m_ramp;
`else
        w.re  = conv(m_a);
        w.im  = conv(m_b);
`endif
        return w;
    endfunction

    task automatic model_clear();
        q.delete();
        m_a = '0; m_b = '0; m_ramp = '0;
        left = 0; keep = 1'b0; m_drops = 0;
    endtask

    // One clock edge of the capture path, given the inputs held across that edge.
    task automatic model_step(input bit e, input bit r, input logic [13:0] a, input logic [13:0] b);
        int free;
        free = FD - q.size();
        if (q.size() != 0 && r) void'(q.pop_front());
        if (left == 0) begin
            if (e) begin
                left = FL - 1;
                keep = (free >= FL);
                if (keep) begin
                    q.push_back(make_word(1'b1, 1'b0));
                    m_ramp++;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
        end else begin
            if (keep) begin
                q.push_back(make_word(1'b0, left == 1));
                m_ramp++;
            end
            left--;
        end
        m_a = a;
        m_b = b;
    endtask

    task automatic compare();
        word_t h;
        check("valid", 64'(bus.valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            check("data", 64'(bus.data), 64'({h.re, h.im, 6'd0}));
            check("sop", 64'(bus.startofpacket), 64'(h.sop));
            check("eop", 64'(bus.endofpacket), 64'(h.eop));
        end
        check("busy", 64'(busy), 64'(left != 0));
        check("drop_count", 64'(drops), 64'(m_drops));
    endtask

    task automatic cycle(input bit e, input bit r, input logic [13:0] a, input logic [13:0] b);
        @(negedge clk);
        compare();
        en = e;
        bus.ready = r;
        cha = a;
        chb = b;
        if (bus.valid && r) hs_count++;
        model_step(e, r, a, b);
    endtask

    function automatic logic [13:0] rnd14();
        return 14'($urandom);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.valid), 64'd0);
        check({tag, "_data"}, 64'(bus.data), 64'd0);
        check({tag, "_sop"}, 64'(bus.startofpacket), 64'd0);
        check({tag, "_eop"}, 64'(bus.endofpacket), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_drops"}, 64'(drops), 64'd0);
    endtask

    logic [13:0] tbl [4];
    int          start_hs;
    bit          reached;

    initial begin
        tbl[0] = 14'h2000; tbl[1] = 14'h3FFF; tbl[2] = 14'h0000; tbl[3] = 14'h2004;
        bus.ready = 1'b0;
        model_clear();

        // Reset state, then release on a falling edge.
        #2 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_step(en, bus.ready, cha, chb);

        // Conversion table leads frame 0; three frames back to back with ready high.
        cycle(1'b0, 1'b1, tbl[0], tbl[0]);
        start_hs = hs_count;
        for (int i = 1; i <= 3 * FL; i++) begin
            if (i < 4) cycle(1'b1, 1'b1, tbl[i], tbl[i]);
            else       cycle(1'b1, 1'b1, rnd14(), rnd14());
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, rnd14(), rnd14());
        check("framing_words", 64'(hs_count - start_hs), 64'(3 * FL));

        // Backpressure: two frames fit, the third is skipped, then exactly two frames drain.
        for (int i = 0; i < 3 * FL; i++) cycle(1'b1, 1'b0, rnd14(), rnd14());
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, rnd14(), rnd14());
        check("bp_drop_count", 64'(drops), 64'd1);
        start_hs = hs_count;
        for (int i = 0; i < 2 * FD; i++) cycle(1'b0, 1'b1, rnd14(), rnd14());
        check("bp_drain_words", 64'(hs_count - start_hs), 64'(2 * FL));

        // Enable falls at cnt=10: the frame still completes and nothing new starts.
        reached = 1'b0;
        for (int i = 0; i < 4 * FL && !reached; i++) begin
            cycle(1'b1, 1'b1, rnd14(), rnd14());
            reached = (left == FL - 10);
        end
        check("reach_cnt10", 64'(reached), 64'd1);
        start_hs = hs_count;
        for (int i = 0; i < 2 * FL; i++) cycle(1'b0, 1'b1, rnd14(), rnd14());
        check("midframe_words", 64'(hs_count - start_hs), 64'(FL - 10 + 1));

        // Random enable and backpressure, with drops expected along the way.
        for (int i = 0; i < 4000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, rnd14(), rnd14());

        // Reset at cnt=30: outputs clear immediately; the next word after release opens a packet.
        reached = 1'b0;
        for (int i = 0; i < 4 * FL && !reached; i++) begin
            cycle(1'b1, 1'b1, rnd14(), rnd14());
            reached = keep && (left == FL - 30);
        end
        check("reach_cnt30", 64'(reached), 64'd1);
        @(negedge clk);
        compare();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(en, bus.ready, cha, chb);
        for (int i = 0; i < 8 && !bus.valid; i++) cycle(1'b1, 1'b1, rnd14(), rnd14());
        check("valid_after_reset", 64'(bus.valid), 64'd1);
        check("sop_after_reset", 64'(bus.startofpacket), 64'd1);

        for (int i = 0; i < 3 * FL; i++) cycle(1'b1, 1'b1, rnd14(), rnd14());
        for (int i = 0; i < 2 * FD; i++) cycle(1'b0, 1'b1, rnd14(), rnd14());
        check("final_empty", 64'(bus.valid), 64'd0);
        check("final_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
